// File: rtl/alarm_sounder.sv
// alarm_sounder: alarm clock ringer with snooze, auto-stop and a gated square-wave tone
module alarm_sounder #(
   parameter int TONE_DIV    = 67568,
   parameter int CNT_W       = 17,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cur_time,
   input  logic [15:0] alm_time,
   input  logic        alarm_en,
   input  logic        sec_tick,
   input  logic        snooze,
   input  logic        stop,
   output logic        speaker,
   output logic        vcc,
   output logic        ringing,
   output logic        snoozing,
   output logic [3:0]  snooze_left
);
   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
   localparam logic [15:0]      RING_END = 16'(RING_SECS - 1);
   localparam logic [15:0]      SNZ_END  = 16'(SNOOZE_SECS - 1);
   localparam logic [CNT_W-1:0] TONE_END = CNT_W'(TONE_DIV - 1);
   localparam logic [3:0]       SNZ_MAX  = 4'(MAX_SNOOZE);
   state_t           r_state, w_nxt;
   logic             r_match_q, r_ring, r_snz, r_tone, r_gate;
   logic [15:0]      r_sec_cnt;
   logic [CNT_W-1:0] r_tone_cnt;
   logic [3:0]       r_snooze_left;
   logic             w_match, w_trig, w_stay_ring, w_tone_wrap;
   assign w_match     = cur_time == alm_time;
   assign w_trig      = alarm_en && w_match && !r_match_q;
   assign w_stay_ring = r_state == RING && w_nxt == RING;
   assign w_tone_wrap = r_tone_cnt == TONE_END;
   assign speaker     = r_tone & r_gate;
   assign vcc         = 1'b1;
   assign ringing     = r_ring;
   assign snoozing    = r_snz;
   assign snooze_left = r_snooze_left;
   // next state: disable beats stop beats snooze beats timeout
   always_comb begin
      w_nxt = r_state;
      if (r_state == IDLE) w_nxt = (w_trig && !stop) ? RING : IDLE;
      else if (!alarm_en || stop) w_nxt = IDLE;
      else if (r_state == RING && snooze && r_snooze_left != 4'd0) w_nxt = SNOOZE;
      else if (sec_tick && r_state == RING && r_sec_cnt == RING_END) w_nxt = IDLE;
      else if (sec_tick && r_state == SNOOZE && r_sec_cnt == SNZ_END) w_nxt = RING;
   end
   // state, registered decodes, second counter, snooze budget and tone generator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_ring        <= 1'b0;
         r_snz         <= 1'b0;
         r_match_q     <= 1'b1;
         r_sec_cnt     <= '0;
         r_snooze_left <= SNZ_MAX;
         r_tone_cnt    <= '0;
         r_tone        <= 1'b0;
         r_gate        <= 1'b0;
      end else begin
         r_state       <= w_nxt;
         r_ring        <= w_nxt == RING;
         r_snz         <= w_nxt == SNOOZE;
         r_match_q     <= w_match;
         r_sec_cnt     <= (w_nxt != r_state) ? '0 : (sec_tick && r_state != IDLE) ? r_sec_cnt + 16'd1 : r_sec_cnt;
         r_snooze_left <= (w_nxt == IDLE) ? SNZ_MAX : (r_state == RING && w_nxt == SNOOZE) ? r_snooze_left - 4'd1 : r_snooze_left;
         r_tone_cnt    <= (!w_stay_ring || w_tone_wrap) ? '0 : r_tone_cnt + CNT_W'(1);
         r_tone        <= w_stay_ring && (r_tone ^ w_tone_wrap);
         r_gate        <= (w_nxt != RING) ? 1'b0 : (r_state != RING) ? 1'b1 : r_gate ^ sec_tick;
      end
   end
endmodule

// File: tb/tb_alarm_sounder.sv
// tb_alarm_sounder: randomized scoreboard bench against a behavioural alarm model
module tb_alarm_sounder;
   localparam int TD = 4, CW = 3, RS = 4, SS = 3, MS = 1;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [15:0] cur_time, alm_time;
   logic alarm_en, sec_tick, snooze, stop;
   logic speaker, vcc, ringing, snoozing;
   logic [3:0] snooze_left;
   typedef struct packed {logic ring; logic snz; logic spk; logic [3:0] left;} exp_t;
   exp_t q[$];
   int checks = 0, passes = 0;
   bit started = 0;
   bit m_ring, m_snz, m_pm;
   int m_secs, m_cyc, m_ticks, m_taken;

   alarm_sounder #(.TONE_DIV(TD), .CNT_W(CW), .RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
      .clk(clk), .rst_n(rst_n), .cur_time(cur_time), .alm_time(alm_time), .alarm_en(alarm_en),
      .sec_tick(sec_tick), .snooze(snooze), .stop(stop), .speaker(speaker), .vcc(vcc),
      .ringing(ringing), .snoozing(snoozing), .snooze_left(snooze_left));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // speaker: gate on during even-numbered seconds of ringing, tone high in odd half-periods
   function automatic exp_t m_out();
      exp_t e;
      e.ring = m_ring;
      e.snz  = m_snz;
      e.spk  = m_ring && (m_ticks % 2 == 0) && ((m_cyc / TD) % 2 == 1);
      e.left = 4'(MS - m_taken);
      return e;
   endfunction

   task automatic m_reset();
      m_ring = 0; m_snz = 0; m_pm = 1; m_secs = 0; m_cyc = 0; m_ticks = 0; m_taken = 0;
   endtask

   task automatic m_enter_ring();
      m_ring = 1; m_snz = 0; m_secs = 0; m_cyc = 0; m_ticks = 0;
   endtask

   task automatic m_step();
      bit match, trig;
      match = cur_time == alm_time;
      trig  = alarm_en && match && !m_pm;
      m_pm  = match;
      if (!m_ring && !m_snz) begin
         if (trig && !stop) m_enter_ring();
      end else if (!alarm_en || stop) begin
         m_ring = 0; m_snz = 0; m_taken = 0;
      end else if (m_ring && snooze && m_taken < MS) begin
         m_taken++; m_ring = 0; m_snz = 1; m_secs = 0;
      end else if (sec_tick && m_ring && m_secs == RS - 1) begin
         m_ring = 0; m_taken = 0;
      end else if (sec_tick && m_snz && m_secs == SS - 1) begin
         m_enter_ring();
      end else begin
         if (sec_tick) m_secs++;
         if (m_ring) begin
            m_cyc++;
            if (sec_tick) m_ticks++;
         end
      end
   endtask

   initial begin
      exp_t e;
      alm_time = 16'h0700; cur_time = 16'h0700;
      alarm_en = 1; sec_tick = 0; snooze = 0; stop = 0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("reset_speaker", speaker, 0);
      chk("reset_ringing", ringing, 0);
      chk("reset_snoozing", snoozing, 0);
      chk("reset_snooze_left", snooze_left, MS);
      chk("reset_vcc", vcc, 1);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst_n    = 1;
         sec_tick = $urandom_range(3) == 0;
         snooze   = $urandom_range(15) == 0;
         stop     = $urandom_range(47) == 0;
         if ($urandom_range(29) == 0) cur_time = (cur_time == 16'h0700) ? 16'h0659 : 16'h0700;
         if (alarm_en ? $urandom_range(79) == 0 : $urandom_range(3) == 0) alarm_en = !alarm_en;
         e = m_out();
         if ($urandom_range(299) == 0 || (e.spk && $urandom_range(39) == 0)) begin
            rst_n = 0;
            #1;
            chk("async_rst_speaker", speaker, 0);
            chk("async_rst_ringing", ringing, 0);
            chk("async_rst_snoozing", snoozing, 0);
            chk("async_rst_left", snooze_left, MS);
            m_reset();
         end else m_step();
         q.push_back(m_out());
         started = 1;
      end
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      exp_t e;
      wait (started);
      forever begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("ringing", ringing, e.ring);
            chk("snoozing", snoozing, e.snz);
            chk("speaker", speaker, e.spk);
            chk("snooze_left", snooze_left, e.left);
            chk("vcc", vcc, 1);
         end
      end
   end
endmodule

// File: doc/alarm_sounder.md
ALARM_SOUNDER -- requirements
Module: alarm_sounder

Interface
REQ-001 Parameter TONE_DIV, default 67568, clk cycles per speaker half-period (legal range 2..2^CNT_W).
REQ-002 Parameter CNT_W, default 17, tone counter width.
REQ-003 Parameter RING_SECS, default 60, seconds of ringing before auto-stop (legal range 1..255).
REQ-004 Parameter SNOOZE_SECS, default 300, seconds of silence per snooze (legal range 1..65535).
REQ-005 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (legal range 0..15).
REQ-006 clk  input  1  main clock, all logic on rising edge.
REQ-007 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-008 cur_time  input  16  current time, BCD {hr_tens, hr_ones, min_tens, min_ones}.
REQ-009 alm_time  input  16  alarm time, same BCD format.
REQ-010 alarm_en  input  1  level; alarm armed when 1.
REQ-011 sec_tick  input  1  one-cycle pulse, once per second.
REQ-012 snooze  input  1  one-cycle pulse, snooze request.
REQ-013 stop  input  1  one-cycle pulse, dismiss request.
REQ-014 speaker  output  1  square-wave tone to speaker.
REQ-015 vcc  output  1  speaker supply, constant 1.
REQ-016 ringing  output  1  high in state RING.
REQ-017 snoozing  output  1  high in state SNOOZE.
REQ-018 snooze_left  output  4  remaining snoozes, MAX_SNOOZE minus snoozes taken.

Function
REQ-019 FSM states IDLE, RING, SNOOZE; ringing/snoozing are registered state decodes.
REQ-020 match = (cur_time == alm_time), registered each cycle into match_q.
REQ-021 Trigger = alarm_en & match & ~match_q (rising edge of match only); a held match never retriggers.
REQ-022 IDLE -> RING on trigger, unless stop is high in the same cycle (stop wins, stay IDLE).
REQ-023 Transition priority, every state: ~alarm_en > stop > snooze > timeout; ~alarm_en or stop -> IDLE next cycle.
REQ-024 RING + snooze with snooze_left > 0 -> SNOOZE, snooze_left decrements by 1.
REQ-025 RING + snooze with snooze_left == 0 -> ignored, stay RING.
REQ-026 SNOOZE + snooze -> ignored.
REQ-027 Second counter sec_cnt clears on every state entry; increments on sec_tick in RING/SNOOZE.
REQ-028 RING timeout: sec_tick while sec_cnt == RING_SECS-1 -> IDLE.
REQ-029 SNOOZE timeout: sec_tick while sec_cnt == SNOOZE_SECS-1 -> RING.
REQ-030 snooze_left reloads to MAX_SNOOZE on entry to IDLE; it does not reload on SNOOZE -> RING.
REQ-031 Tone counter runs 0..TONE_DIV-1 only in RING and wraps to 0.
REQ-032 The tone bit toggles in the cycle the tone counter wraps.
REQ-033 The tone counter and tone bit are held at 0 outside RING, so the phase restarts on every RING entry.
REQ-034 Beep gate is set to 1 on RING entry, toggles on each sec_tick in RING, and is 0 outside RING (1 s on / 1 s off cadence).
REQ-035 speaker = tone & gate; guaranteed 0 outside RING.
REQ-036 sec_tick coincident with a state transition is consumed by the transition and does not count in the new state.
REQ-037 Time inputs are assumed stable across a minute; no BCD validity checking.

Reset
REQ-038 rst_n low asynchronously forces state IDLE, match_q=1, sec_cnt=0, tone counter=0, tone=0, gate=0, snooze_left=MAX_SNOOZE.
REQ-039 Output values during reset: speaker=0, ringing=0, snoozing=0, vcc=1.
REQ-040 match_q=1 at reset prevents a trigger if the time already matches at reset release.
REQ-041 Reset mid-RING or mid-SNOOZE silences the speaker immediately; the alarm resumes only on the next match edge.

Verification (TONE_DIV=4, RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=1)
REQ-042 Scenario 1: alarm_en=1, cur_time steps 0659->0700 = alm_time -> ringing=1 one cycle after match edge; speaker period 8 clk while gate=1; speaker=0 after first sec_tick.
REQ-043 Scenario 2: no input after trigger -> ringing drops on 4th sec_tick; no retrigger while cur_time stays 0700.
REQ-044 Scenario 3: snooze in RING -> snoozing=1, snooze_left=0, speaker=0; 3rd sec_tick -> RING; second snooze ignored.
REQ-045 Scenario 4: stop and snooze in the same cycle during RING -> IDLE, snooze_left=1.
REQ-046 Scenario 5: alarm_en dropped during SNOOZE -> IDLE next cycle, no ring after the snooze period.
REQ-047 Scenario 6: rst_n pulsed low mid-RING with match held -> speaker=0 asynchronously; state stays IDLE after release until cur_time changes and matches again.
